// File: rtl/pulse_seq_arbiter_pkg.sv
// Shared encodings for the pulse sequencer arbiter: the sequencer state values it observes
// and its own FSM state type.
package pulse_seq_arbiter_pkg;

  localparam logic [1:0] SEQ_ST_INIT          = 2'd0;
  localparam logic [1:0] SEQ_ST_WAITING_TIMER = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pulse_seq_arbiter_rr_priority_pick.sv
// Round-robin pick: finds the first set request bit scanning upward from ptr+1, wrapping
// modulo N_REQ, and returns it both one-hot and as an index.
module rr_priority_pick #(
  parameter int N_REQ      = 4,
  parameter int LOG2_N_REQ = 2
) (
  input  logic [N_REQ-1:0]      i_req,
  input  logic [LOG2_N_REQ-1:0] i_ptr,
  output logic                  o_any,
  output logic [N_REQ-1:0]      o_grant,
  output logic [LOG2_N_REQ-1:0] o_idx
);

  logic [LOG2_N_REQ-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest set bit overwrites last.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = LOG2_N_REQ'((int'(i_ptr) + k) % N_REQ);
      if (i_req[cand]) begin
        o_any       = 1'b1;
        o_grant     = '0;
        o_grant[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_seq_arbiter.sv
// Round-robin arbiter that hands one shared pulse sequencer to one requester at a time,
// latching that requester's step profile and guarding the run with a watchdog.
module pulse_seq_arbiter
  import pulse_seq_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LOG2_N_REQ = 2,
  parameter int N_STEPS    = 5,
  parameter int NB_TIMER   = 4,
  parameter int NB_STATE   = 2,
  parameter int NB_WDOG    = 8
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_valid,
  input  logic [N_REQ-1:0]                  i_req_bus,
  input  logic [N_REQ*N_STEPS*NB_TIMER-1:0] i_limit_table,
  input  logic [NB_WDOG-1:0]                i_wdog_limit,
  input  logic [NB_STATE-1:0]               i_seq_state,
  output logic                              o_seq_trigger,
  output logic                              o_seq_reset,
  output logic [N_STEPS*NB_TIMER-1:0]       o_seq_limit_bus,
  output logic [N_REQ-1:0]                  o_grant_bus,
  output logic [N_REQ-1:0]                  o_done_bus,
  output logic                              o_error
);

  localparam int NB_PROF = N_STEPS * NB_TIMER;

  arb_state_e            state_q, state_d;
  logic [LOG2_N_REQ-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [NB_PROF-1:0]    prof_q, prof_d;
  logic [NB_WDOG-1:0]    wdog_q, wdog_d;

  logic                  pick_any;
  logic [N_REQ-1:0]      pick_grant;
  logic [LOG2_N_REQ-1:0] pick_idx;
  logic [NB_PROF-1:0]    prof_raw;
  logic [NB_PROF-1:0]    prof_clamped;
  logic                  seq_idle;
  logic                  wdog_expire;

  rr_priority_pick #(
    .N_REQ      (N_REQ),
    .LOG2_N_REQ (LOG2_N_REQ)
  ) u_pick (
    .i_req   (i_req_bus),
    .i_ptr   (ptr_q),
    .o_any   (pick_any),
    .o_grant (pick_grant),
    .o_idx   (pick_idx)
  );

  assign prof_raw = i_limit_table[int'(pick_idx)*NB_PROF +: NB_PROF];

  // A zero limit would make the sequencer count limit-1 and wrap to a full-scale step.
  for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_clamp
    assign prof_clamped[gi*NB_TIMER +: NB_TIMER] =
      (prof_raw[gi*NB_TIMER +: NB_TIMER] == '0) ? NB_TIMER'(1) : prof_raw[gi*NB_TIMER +: NB_TIMER];
  end

  assign seq_idle    = (i_seq_state == NB_STATE'(SEQ_ST_INIT));
  // Completion wins over expiry when both land in the same cycle.
  assign wdog_expire = (state_q == ST_BUSY) && !seq_idle && (i_wdog_limit != '0) &&
                       (({1'b0, wdog_q} + (NB_WDOG+1)'(1)) >= {1'b0, i_wdog_limit});

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    prof_d  = prof_q;
    wdog_d  = wdog_q;
    if (i_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            prof_d  = prof_clamped;
            grant_d = pick_grant;
            ptr_d   = pick_idx;
            wdog_d  = '0;
            state_d = ST_LAUNCH;
          end
        end
        ST_LAUNCH: state_d = ST_BUSY;
        ST_BUSY: begin
          if (seq_idle || wdog_expire) begin
            state_d = ST_DONE;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + NB_WDOG'(1);
          end
        end
        ST_DONE: begin
          grant_d = '0;
          wdog_d  = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= LOG2_N_REQ'(N_REQ - 1);
      grant_q <= '0;
      prof_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      prof_q  <= prof_d;
      wdog_q  <= wdog_d;
    end
  end

  assign o_seq_trigger   = (state_q == ST_LAUNCH);
  assign o_seq_reset     = wdog_expire;
  assign o_error         = wdog_expire;
  assign o_seq_limit_bus = prof_q;
  assign o_grant_bus     = grant_q;
  assign o_done_bus      = (state_q == ST_DONE) ? grant_q : '0;

endmodule

// File: tb/tb_pulse_seq_arbiter.sv
// Directed bench for pulse_seq_arbiter; the sequencer state input is driven by hand to
// emulate the shared sequencer's INIT / WAITING_TIMER phases.
module tb_pulse_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  req;
  logic [79:0] table_bus;
  logic [7:0]  wdog_limit;
  logic [1:0]  seq_state;
  logic        trig, seq_rst, err;
  logic [19:0] limit_bus;
  logic [3:0]  grant, done;

  int checks = 0;
  int errors = 0;
  int early_err;

  // Requester profiles (step 4 .. step 0 as hex digits) and their clamped forms.
  localparam logic [19:0] P0 = 20'h22222, P0C = 20'h22222;
  localparam logic [19:0] P1 = 20'h33033, P1C = 20'h33133;
  localparam logic [19:0] P2 = 20'h12345, P2C = 20'h12345;
  localparam logic [19:0] P3 = 20'h00000, P3C = 20'h11111;

  logic [3:0]  exp_grant [5];
  logic [19:0] exp_prof  [5];

  always #5 clk = ~clk;

  pulse_seq_arbiter dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_valid         (valid),
    .i_req_bus       (req),
    .i_limit_table   (table_bus),
    .i_wdog_limit    (wdog_limit),
    .i_seq_state     (seq_state),
    .o_seq_trigger   (trig),
    .o_seq_reset     (seq_rst),
    .o_seq_limit_bus (limit_bus),
    .o_grant_bus     (grant),
    .o_done_bus      (done),
    .o_error         (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    valid      = 1'b1;
    req        = 4'b0000;
    table_bus  = {P3, P2, P1, P0};
    wdog_limit = 8'd0;
    seq_state  = 2'd0;
    do_reset();

    // Reset state
    check("rst_grant", grant, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_trig", trig, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_seqrst", seq_rst, 1'b0);
    check("rst_limit", limit_bus, 20'h0);

    // Single requester, profile isolation and withdrawal mid-run
    req = 4'b0001;
    step();
    check("t1_trig", trig, 1'b1);
    check("t1_grant", grant, 4'b0001);
    check("t1_limit", limit_bus, P0C);
    seq_state = 2'd1;
    step();
    check("t1_trig_off", trig, 1'b0);
    table_bus = {4{20'hFFFFF}};
    req = 4'b0000;
    step();
    step();
    check("t1_isolate", limit_bus, P0C);
    check("t1_no_done", done, 4'b0000);
    seq_state = 2'd0;
    step();
    check("t1_done", done, 4'b0001);
    step();
    check("t1_done_off", done, 4'b0000);
    check("t1_grant_off", grant, 4'b0000);
    table_bus = {P3, P2, P1, P0};

    // All requesters held: round-robin from requester 0, clamp on zero fields
    do_reset();
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_prof  = '{P0C, P1C, P2C, P3C, P0C};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_grant", grant, exp_grant[i]);
      check("t2_limit", limit_bus, exp_prof[i]);
      seq_state = 2'd1;
      step();
      seq_state = 2'd0;
      step();
      check("t2_done", done, exp_grant[i]);
      step();
      check("t2_done_off", done, 4'b0000);
    end
    req = 4'b0000;

    // Watchdog expiry after 20 BUSY cycles
    do_reset();
    wdog_limit = 8'd20;
    req = 4'b0001;
    step();
    req = 4'b0000;
    seq_state = 2'd1;
    step();
    early_err = 0;
    for (int c = 1; c <= 19; c++) begin
      if (err !== 1'b0 || done !== 4'b0000) early_err++;
      step();
    end
    check("t4_early", early_err, 0);
    check("t4_err", err, 1'b1);
    check("t4_seqrst", seq_rst, 1'b1);
    check("t4_grant", grant, 4'b0001);
    step();
    check("t4_done", done, 4'b0001);
    check("t4_err_off", err, 1'b0);
    seq_state = 2'd0;
    step();
    check("t4_idle", grant, 4'b0000);

    // Expiry coinciding with completion counts as normal completion
    wdog_limit = 8'd3;
    req = 4'b0001;
    step();
    req = 4'b0000;
    seq_state = 2'd1;
    step();
    step();
    step();
    check("t4b_expire", err, 1'b1);
    seq_state = 2'd0;
    #1;
    check("t4b_err_sim", err, 1'b0);
    check("t4b_rst_sim", seq_rst, 1'b0);
    step();
    check("t4b_done", done, 4'b0001);
    step();
    wdog_limit = 8'd0;

    // Valid toggling freezes the FSM and holds outputs
    do_reset();
    req = 4'b0100;
    valid = 1'b0;
    step();
    check("t5_frozen", grant, 4'b0000);
    valid = 1'b1;
    step();
    check("t5_trig", trig, 1'b1);
    check("t5_grant", grant, 4'b0100);
    valid = 1'b0;
    step();
    check("t5_trig_hold", trig, 1'b1);
    req = 4'b0000;
    valid = 1'b1;
    seq_state = 2'd1;
    step();
    check("t5_trig_off", trig, 1'b0);
    valid = 1'b0;
    seq_state = 2'd0;
    step();
    check("t5_busy_hold", done, 4'b0000);
    valid = 1'b1;
    step();
    check("t5_done", done, 4'b0100);
    valid = 1'b0;
    step();
    check("t5_done_hold", done, 4'b0100);
    valid = 1'b1;
    step();
    check("t5_done_off", done, 4'b0000);

    // Reset in BUSY
    req = 4'b0010;
    step();
    seq_state = 2'd1;
    step();
    check("t6_busy", grant, 4'b0010);
    req = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_grant", grant, 4'b0000);
    check("t6_trig", trig, 1'b0);
    check("t6_done", done, 4'b0000);
    check("t6_limit", limit_bus, 20'h0);
    seq_state = 2'd0;
    req = 4'b1111;
    step();
    check("t6_regrant", grant, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
